dot_vec_feeder: RTL and testbench

- Host-side driver for the 8-element, 16-bit sequential dot-product unit.
- Accepts a serial stream of element pairs (a_i, b_i) over a valid/ready handshake and packs them into 128-bit operand vectors.
- Clears the unit, lets it run for exactly ELEMS accumulation cycles, then captures the result and returns it over a valid/ready output.
- Sits between the stream source and one dot-product lane.

---
 rtl/dot_vec_feeder_if.sv | 34 +++
 rtl/dot_vec_feeder.sv | 161 ++++++++++++++++
 tb/tb_dot_vec_feeder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dot_vec_feeder_if.sv
// Bundle of the stream input, dot-product lane and result signals around
// dot_vec_feeder. The feeder takes the slave view; the surrounding
// environment (stream source, dot-product unit, consumer) takes the master view.
interface dot_vec_feeder_if #(
  parameter int ELEMS = 8,
  parameter int EW    = 16,
  parameter int RW    = 36
);
  // element pair stream
  logic                  in_valid;
  logic                  in_ready;
  logic [EW-1:0]         in_a;
  logic [EW-1:0]         in_b;
  // dot-product lane
  logic [ELEMS*EW-1:0]   vec_a;
  logic [ELEMS*EW-1:0]   vec_b;
  logic                  dp_clr;
  logic [RW-1:0]         dp_c;
  // result stream
  logic                  res_valid;
  logic                  res_ready;
  logic [RW-1:0]         res_data;
  logic [15:0]           res_count;

  modport slave (
    input  in_valid, in_a, in_b, dp_c, res_ready,
    output in_ready, vec_a, vec_b, dp_clr, res_valid, res_data, res_count
  );

  modport master (
    output in_valid, in_a, in_b, dp_c, res_ready,
    input  in_ready, vec_a, vec_b, dp_clr, res_valid, res_data, res_count
  );
endinterface

// File: rtl/dot_vec_feeder.sv
// Host-side driver for one sequential dot-product lane: packs a serial stream
// of (a_i, b_i) pairs into operand vectors, runs the lane for ELEMS cycles,
// captures its result and hands it out over a valid/ready port.
module dot_vec_feeder #(
  parameter int ELEMS = 8,
  parameter int EW    = 16,
  parameter int RW    = 36
) (
  input logic              clk,
  input logic              rst,
  dot_vec_feeder_if.slave  bus
);

  localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);

  // The lane's sum must fit the result path, which is passed through untouched.
  generate
    if (RW < 2 * EW + $clog2(ELEMS)) begin : g_bad_rw
      $error("dot_vec_feeder: RW too narrow for ELEMS products of EW bits");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [IDX_W-1:0]  run_cnt_reg, run_cnt_next;
  logic              res_valid_reg, res_valid_next;
  logic [RW-1:0]     res_data_reg;
  logic [15:0]       res_count_reg;

  logic              accept;
  logic              capture;
  logic              res_hs;
  logic              in_ready_dec;
  logic              dp_clr_dec;

  // State register and counters; reset discards any partial vector or run.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= ST_LOAD;
      idx_reg       <= '0;
      run_cnt_reg   <= '0;
      res_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      run_cnt_reg   <= run_cnt_next;
      res_valid_reg <= res_valid_next;
    end
  end

  // Next-state and decode; in_ready/dp_clr depend on the state only.
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    run_cnt_next   = run_cnt_reg;
    res_valid_next = res_valid_reg;
    in_ready_dec   = 1'b0;
    dp_clr_dec     = 1'b1;
    accept         = 1'b0;
    capture        = 1'b0;
    res_hs         = 1'b0;
    case (state_reg)
      ST_LOAD: begin
        in_ready_dec = 1'b1;
        dp_clr_dec   = 1'b1;
        accept       = bus.in_valid;
        if (accept) begin
          if (idx_reg == LAST_IDX) begin
            idx_next     = '0;
            run_cnt_next = '0;
            state_next   = ST_RUN;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      ST_RUN: begin
        dp_clr_dec = 1'b0;
        if (run_cnt_reg == LAST_IDX) begin
          run_cnt_next = '0;
          state_next   = ST_WAIT;
        end else begin
          run_cnt_next = run_cnt_reg + 1'b1;
        end
      end
      ST_WAIT: begin
        // lane has finished ELEMS accumulations; its output is final here
        dp_clr_dec     = 1'b0;
        capture        = 1'b1;
        res_valid_next = 1'b1;
        state_next     = ST_OUT;
      end
      ST_OUT: begin
        dp_clr_dec = 1'b1;
        res_hs     = res_valid_reg && bus.res_ready;
        if (res_hs) begin
          res_valid_next = 1'b0;
          state_next     = ST_LOAD;
        end
      end
      default: begin
        state_next     = ST_LOAD;
        idx_next       = '0;
        run_cnt_next   = '0;
        res_valid_next = 1'b0;
      end
    endcase
  end

  // One register pair per element lane; a lane loads when the beat index hits it.
  generate
    for (genvar gi = 0; gi < ELEMS; gi++) begin : g_lane
      logic [EW-1:0] lane_a_reg;
      logic [EW-1:0] lane_b_reg;

      // Capture this lane's element on an accepted beat addressed to it.
      always_ff @(posedge clk) begin
        if (!rst) begin
          lane_a_reg <= '0;
          lane_b_reg <= '0;
        end else if (accept && (idx_reg == IDX_W'(gi))) begin
          lane_a_reg <= bus.in_a;
          lane_b_reg <= bus.in_b;
        end
      end

      assign bus.vec_a[gi*EW +: EW] = lane_a_reg;
      assign bus.vec_b[gi*EW +: EW] = lane_b_reg;
    end
  endgenerate

  // Result capture from the lane and completed-handshake counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      res_data_reg  <= '0;
      res_count_reg <= '0;
    end else begin
      if (capture) begin
        res_data_reg <= bus.dp_c;
      end
      if (res_hs) begin
        res_count_reg <= res_count_reg + 16'd1;
      end
    end
  end

  assign bus.in_ready  = in_ready_dec;
  assign bus.dp_clr    = dp_clr_dec;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_data  = res_data_reg;
  assign bus.res_count = res_count_reg;

endmodule

// File: tb/tb_dot_vec_feeder.sv
// Directed bench for dot_vec_feeder with a behavioural sequential dot-product
// lane attached to the vector/clear/result signals.
module tb_dot_vec_feeder;
  localparam int ELEMS = 8;
  localparam int EW    = 16;
  localparam int RW    = 36;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dot_vec_feeder_if #(.ELEMS(ELEMS), .EW(EW), .RW(RW)) bus ();

  dot_vec_feeder #(.ELEMS(ELEMS), .EW(EW), .RW(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Lane model: clear while dp_clr, else one multiply-accumulate per cycle.
  logic [RW-1:0] acc = '0;
  int            k   = 0;
  always @(posedge clk) begin
    if (bus.dp_clr) begin
      acc <= '0;
      k   <= 0;
    end else if (k < ELEMS) begin
      acc <= acc + RW'(bus.vec_a[k*EW +: EW]) * RW'(bus.vec_b[k*EW +: EW]);
      k   <= k + 1;
    end
  end
  assign bus.dp_c = acc;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push ELEMS beats with 'gap' idle cycles before each beat.
  task automatic send_beats(input logic [127:0] va, input logic [127:0] vb, input int gap);
    for (int i = 0; i < ELEMS; i++) begin
      bus.in_valid = 1'b0;
      repeat (gap) tick();
      bus.in_valid = 1'b1;
      bus.in_a     = va[i*EW +: EW];
      bus.in_b     = vb[i*EW +: EW];
      begin
        int n = 0;
        while (!bus.in_ready && n < 100) begin
          tick();
          n++;
        end
        if (n >= 100) check_val("in_ready_timeout", 0, 1);
      end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  // Full transaction: send, check latency, hold, handshake, check result/count.
  task automatic run_vec(input string name, input logic [127:0] va, input logic [127:0] vb,
                         input int gap, input int hold, input logic [RW-1:0] exp,
                         input logic [15:0] exp_cnt);
    int lat;
    send_beats(va, vb, gap);
    check_val({name, "_vec_a"}, bus.vec_a, va);
    check_val({name, "_vec_b"}, bus.vec_b, vb);
    lat = 0;
    while (!bus.res_valid && lat < 50) begin
      tick();
      lat++;
    end
    check_val({name, "_latency"}, lat, 9);
    check_val({name, "_res_data"}, bus.res_data, exp);
    bus.res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = h[0];
      bus.in_a     = 16'hDEAD;
      bus.in_b     = 16'hBEEF;
      tick();
      check_val({name, "_hold_valid"}, bus.res_valid, 1);
      check_val({name, "_hold_data"}, bus.res_data, exp);
      check_val({name, "_hold_in_ready"}, bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    if (hold > 0) check_val({name, "_hold_vec_a"}, bus.vec_a, va);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check_val({name, "_post_valid"}, bus.res_valid, 0);
    check_val({name, "_post_in_ready"}, bus.in_ready, 1);
    check_val({name, "_count"}, bus.res_count, exp_cnt);
    $display("txn %s: res_data=%0h count=%0d", name, bus.res_data, bus.res_count);
  endtask

  initial begin
    logic [127:0] va, vb;
    bus.in_valid  = 1'b1;
    bus.in_a      = 16'h1234;
    bus.in_b      = 16'h5678;
    bus.res_ready = 1'b0;

    // 1. reset with live input
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_a = 16'($urandom);
      bus.in_b = 16'($urandom);
      tick();
    end
    check_val("rst_in_ready", bus.in_ready, 1);
    check_val("rst_dp_clr", bus.dp_clr, 1);
    check_val("rst_res_valid", bus.res_valid, 0);
    check_val("rst_vec_a", bus.vec_a, 0);
    check_val("rst_vec_b", bus.vec_b, 0);
    check_val("rst_count", bus.res_count, 0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check_val("rst_no_capture", bus.vec_a, 0);
    $display("txn reset: done");

    // 2. basic 1..8 x 1..8 = 204
    for (int i = 0; i < ELEMS; i++) begin
      va[i*EW +: EW] = 16'(i + 1);
      vb[i*EW +: EW] = 16'(i + 1);
    end
    run_vec("basic", va, vb, 0, 0, 36'd204, 16'd1);
    check_val("basic_lo", va[15:0], 1);

    // 3. all-ones maximum
    va = {128{1'b1}};
    vb = {128{1'b1}};
    run_vec("max", va, vb, 0, 0, 36'h7FFF00008, 16'd2);

    // 4. bubbles between beats: 2*2 + 3*3 = 13
    va = '0;
    va[15:0]    = 16'd2;
    va[127:112] = 16'd3;
    run_vec("bubble", va, va, 2, 0, 36'd13, 16'd3);

    // 5. backpressure: a=1..8, b=2 -> 72
    for (int i = 0; i < ELEMS; i++) begin
      va[i*EW +: EW] = 16'(i + 1);
      vb[i*EW +: EW] = 16'd2;
    end
    run_vec("bp", va, vb, 0, 5, 36'd72, 16'd4);

    // 6. reset during RUN cycle 4
    va = {ELEMS{16'd3}};
    send_beats(va, va, 0);
    repeat (4) tick();
    check_val("midrun_in_run", bus.dp_clr, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_val("midrun_dp_clr", bus.dp_clr, 1);
    check_val("midrun_in_ready", bus.in_ready, 1);
    check_val("midrun_res_valid", bus.res_valid, 0);
    check_val("midrun_vec_a", bus.vec_a, 0);
    $display("txn midrun_reset: done");
    va = {ELEMS{16'd1}};
    run_vec("after_rst", va, va, 0, 0, 36'd8, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
